// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_tx_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_BAUD   = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LVL_LSB = 8;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  sel;
    logic [3:0]  be;
    logic [31:0] wdata;
  } uart_bus_req_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_sys_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [Width-1:0]         i_wdata,
  output logic [Width-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_level
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_level;
  logic             w_push, w_pop;

  assign o_full  = (r_level == (AW+1)'(Depth));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Bus-attached 8N1 UART transmitter with TX FIFO, STATUS/BAUD/CTRL registers.
// Optional macro UART_TX_IRQ_EN adds a registered transmit-complete irq_o.
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int          FifoDepth    = 8,
  parameter logic [15:0] BaudDivReset = 16'd868
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
`ifdef UART_TX_IRQ_EN
  output logic        irq_o,
`endif
  output logic        uart_tx_o
);

  localparam int LW = $clog2(FifoDepth) + 1;

  uart_bus_req_t w_req;
  logic          w_push_req, w_ovf_set, w_ovf_clr, w_pop, w_full, w_empty, w_busy;
  logic [7:0]    w_fifo_rdata;
  logic [LW-1:0] w_level;
  logic [31:0]   w_rdata;
  logic [15:0]   w_baud_eff, w_reload;
  logic          w_irq_en, w_tx, w_unused;

  logic          r_rvalid, r_err, r_ovf, r_tx_en;
  logic [31:0]   r_rdata;
  logic [15:0]   r_baud;

  tx_state_e     r_state, w_state_n;
  logic [7:0]    r_shift, w_shift_n;
  logic [2:0]    r_bitcnt, w_bitcnt_n;
  logic [15:0]   r_baudcnt, w_baudcnt_n;

  assign w_req = '{rd: req_i & ~we_i, wr: req_i & we_i, sel: addr_i[3:2], be: be_i, wdata: wdata_i};
  assign w_unused = ^{addr_i[31:4], addr_i[1:0], be_i[3:2], wdata_i[31:16]};

  assign gnt_o    = req_i;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  assign w_push_req = w_req.wr & (w_req.sel == UART_TXDATA) & w_req.be[0];
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = w_req.wr & (w_req.sel == UART_STATUS) & w_req.be[0] & w_req.wdata[STAT_OVF];

  uart_tx_fifo #(.Width(8), .Depth(FifoDepth)) u_fifo (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .i_push    (w_push_req),
    .i_pop     (w_pop),
    .i_wdata   (w_req.wdata[7:0]),
    .o_rdata   (w_fifo_rdata),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      r_baud   <= BaudDivReset;
      r_tx_en  <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= w_req.rd ? w_rdata : '0;
      r_err    <= 1'b0;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_req.wr && w_req.sel == UART_BAUD) begin
        if (w_req.be[0]) r_baud[7:0]  <= w_req.wdata[7:0];
        if (w_req.be[1]) r_baud[15:8] <= w_req.wdata[15:8];
      end
      if (w_req.wr && w_req.sel == UART_CTRL && w_req.be[0])
        r_tx_en <= w_req.wdata[CTRL_TX_EN];
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq_en, r_irq;
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_req.wr && w_req.sel == UART_CTRL && w_req.be[0])
        r_irq_en <= w_req.wdata[CTRL_IRQ_EN];
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end
  assign w_irq_en = r_irq_en;
  assign irq_o    = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_req.sel)
      UART_STATUS: begin
        w_rdata[STAT_FULL]                      = w_full;
        w_rdata[STAT_EMPTY]                     = w_empty;
        w_rdata[STAT_BUSY]                      = w_busy;
        w_rdata[STAT_OVF]                       = r_ovf;
        w_rdata[STAT_LVL_LSB +: 8]              = 8'(w_level);
      end
      UART_BAUD:   w_rdata[15:0] = r_baud;
      UART_CTRL: begin
        w_rdata[CTRL_TX_EN]  = r_tx_en;
        w_rdata[CTRL_IRQ_EN] = w_irq_en;
      end
      default:     w_rdata = '0;
    endcase
  end

  // Zero divider is treated as one cycle per bit; counter counts down to 0.
  assign w_baud_eff = (r_baud == '0) ? 16'd1 : r_baud;
  assign w_reload   = w_baud_eff - 16'd1;
  assign w_busy     = (r_state != TX_IDLE);
  assign uart_tx_o  = w_tx;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_baudcnt <= '0;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_bitcnt  <= w_bitcnt_n;
      r_baudcnt <= w_baudcnt_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_bitcnt_n  = r_bitcnt;
    w_baudcnt_n = r_baudcnt;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      TX_IDLE: begin
        if (r_tx_en && !w_empty) begin
          w_pop       = 1'b1;
          w_shift_n   = w_fifo_rdata;
          w_baudcnt_n = w_reload;
          w_state_n   = TX_START;
        end
      end
      TX_START: begin
        w_tx = 1'b0;
        if (r_baudcnt == '0) begin
          w_baudcnt_n = w_reload;
          w_bitcnt_n  = '0;
          w_state_n   = TX_DATA;
        end else w_baudcnt_n = r_baudcnt - 16'd1;
      end
      TX_DATA: begin
        w_tx = r_shift[0];
        if (r_baudcnt == '0) begin
          w_baudcnt_n = w_reload;
          w_shift_n   = r_shift >> 1;
          if (r_bitcnt == 3'd7) w_state_n = TX_STOP;
          else                  w_bitcnt_n = r_bitcnt + 3'd1;
        end else w_baudcnt_n = r_baudcnt - 16'd1;
      end
      TX_STOP: begin
        if (r_baudcnt == '0) w_state_n = TX_IDLE;
        else                 w_baudcnt_n = r_baudcnt - 16'd1;
      end
      default: w_state_n = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register access, framing, FIFO overflow, reset.
module tb_uart_tx_periph;
  import uart_tx_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o, uart_tx_o;
  logic [31:0] rdata_o;
`ifdef UART_TX_IRQ_EN
  logic        irq_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_periph dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .req_i     (req_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
`ifdef UART_TX_IRQ_EN
    .irq_o     (irq_o),
`endif
    .uart_tx_o (uart_tx_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_addr(input logic [1:0] off);
    return {28'd0, off, 2'b00};
  endfunction

  task automatic bus_wr(input logic [1:0] off, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk_sys);
    req_i = 1'b1; we_i = 1'b1; be_i = be; addr_i = reg_addr(off); wdata_i = d;
    @(negedge clk_sys);
    req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    chk("wr_rvalid", rvalid_o, 1'b1);
  endtask

  task automatic bus_rd(input logic [1:0] off, output logic [31:0] d);
    @(negedge clk_sys);
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hf; addr_i = reg_addr(off);
    @(negedge clk_sys);
    req_i = 1'b0;
    d = rdata_o;
    chk("rd_rvalid", rvalid_o, 1'b1);
    chk("rd_err", err_o, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(off, d);
    chk(tag, d, exp);
  endtask

  // Waits for a start bit, then samples each bit at its mid-point.
  task automatic rx_byte(input int b, output logic [7:0] d, output logic ok);
    int   t = 0;
    logic st;
    ok = 1'b0;
    d  = '0;
    while (uart_tx_o !== 1'b0 && t < 500) begin
      @(negedge clk_sys);
      t++;
    end
    if (uart_tx_o !== 1'b0) return;
    repeat (b / 2) @(negedge clk_sys);
    st = uart_tx_o;
    for (int j = 0; j < 8; j++) begin
      repeat (b) @(negedge clk_sys);
      d[j] = uart_tx_o;
    end
    repeat (b) @(negedge clk_sys);
    ok = (st === 1'b0) && (uart_tx_o === 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [39:0] obs, exp;
    logic [9:0]  frame;
    logic [31:0] d32;
    logic [7:0]  rb;
    logic        ok, saw_low;

    req_i = 0; we_i = 0; be_i = 0; addr_i = 0; wdata_i = 0;
    rst_sys_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_tx", uart_tx_o, 1'b1);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst_sys_n = 1'b1;

    rd_chk("rst_status", UART_STATUS, 32'h0000_0002);
    rd_chk("rst_baud", UART_BAUD, 32'd868);
    rd_chk("rst_ctrl", UART_CTRL, 32'd0);

    bus_wr(UART_BAUD, 4'b0010, 32'h0000_0300);
    rd_chk("baud_be1", UART_BAUD, 32'h0000_0364);
    bus_wr(UART_BAUD, 4'b0001, 32'h0000_1234);
    rd_chk("baud_be0", UART_BAUD, 32'h0000_0334);
    bus_wr(UART_BAUD, 4'b0010, 32'h0000_AB00);
    rd_chk("baud_be1b", UART_BAUD, 32'h0000_AB34);

    // 0x55 at BAUD=4: 40-cycle frame starting 2 cycles after the write request.
    bus_wr(UART_BAUD, 4'b0011, 32'd4);
    bus_wr(UART_CTRL, 4'b0001, 32'd1);
    bus_wr(UART_TXDATA, 4'b0001, 32'h55);
    fork
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_sys);
        obs[i] = uart_tx_o;
      end
      begin
        repeat (3) @(negedge clk_sys);
        bus_rd(UART_STATUS, d32);
        chk("busy_in_frame", d32[STAT_BUSY], 1'b1);
      end
    join
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) exp[i] = frame[i / 4];
    chk("frame_55", obs, exp);
    rd_chk("idle_after_frame", UART_STATUS, 32'h0000_0002);

    // Fill past capacity while disabled, then drain.
    bus_wr(UART_CTRL, 4'b0001, 32'd0);
    bus_wr(UART_BAUD, 4'b0011, 32'd2);
    for (int i = 0; i < 9; i++) bus_wr(UART_TXDATA, 4'b0001, i);
    rd_chk("full_ovf", UART_STATUS, 32'h0000_0809);
    bus_wr(UART_CTRL, 4'b0001, 32'd1);
    for (int i = 0; i < 8; i++) begin
      rx_byte(2, rb, ok);
      chk("drain_ok", ok, 1'b1);
      chk("drain_byte", rb, i);
    end
    saw_low = 1'b0;
    repeat (40) begin
      @(negedge clk_sys);
      if (uart_tx_o !== 1'b1) saw_low = 1'b1;
    end
    chk("no_ninth_frame", saw_low, 1'b0);
    rd_chk("drained_status", UART_STATUS, 32'h0000_000A);
    bus_wr(UART_STATUS, 4'b0001, 32'h8);
    rd_chk("ovf_cleared", UART_STATUS, 32'h0000_0002);

    // Back-to-back read then write.
    @(negedge clk_sys);
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hf; addr_i = reg_addr(UART_STATUS);
    #1 chk("b2b_gnt0", gnt_o, 1'b1);
    @(negedge clk_sys);
    chk("b2b_rvalid0", rvalid_o, 1'b1);
    chk("b2b_rdata0", rdata_o, 32'h0000_0002);
    chk("b2b_err0", err_o, 1'b0);
    req_i = 1'b1; we_i = 1'b1; be_i = 4'b0001; addr_i = reg_addr(UART_TXDATA); wdata_i = 32'h41;
    #1 chk("b2b_gnt1", gnt_o, 1'b1);
    @(negedge clk_sys);
    chk("b2b_rvalid1", rvalid_o, 1'b1);
    chk("b2b_rdata1", rdata_o, 32'd0);
    chk("b2b_err1", err_o, 1'b0);
    req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    @(negedge clk_sys);
    chk("b2b_rvalid_off", rvalid_o, 1'b0);
    chk("b2b_rdata_off", rdata_o, 32'd0);
    rx_byte(2, rb, ok);
    chk("b2b_rx_ok", ok, 1'b1);
    chk("b2b_rx_byte", rb, 8'h41);

    // BAUD=0 behaves as 1 cycle per bit.
    bus_wr(UART_BAUD, 4'b0011, 32'd0);
    rd_chk("baud_zero", UART_BAUD, 32'd0);
    bus_wr(UART_TXDATA, 4'b0001, 32'hA5);
    rx_byte(1, rb, ok);
    chk("baud0_ok", ok, 1'b1);
    chk("baud0_byte", rb, 8'hA5);

    // Asynchronous reset in the middle of the first data bit.
    bus_wr(UART_BAUD, 4'b0011, 32'd4);
    bus_wr(UART_TXDATA, 4'b0001, 32'hF0);
    bus_wr(UART_TXDATA, 4'b0001, 32'hF0);
    repeat (2) @(negedge clk_sys);
    bus_rd(UART_STATUS, d32);
    chk("pre_rst_tx", uart_tx_o, 1'b0);
    chk("pre_rst_rvalid", rvalid_o, 1'b1);
    #2 rst_sys_n = 1'b0;
    #1;
    chk("mid_rst_tx", uart_tx_o, 1'b1);
    chk("mid_rst_rvalid", rvalid_o, 1'b0);
    chk("mid_rst_rdata", rdata_o, 32'd0);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    rd_chk("post_rst_status", UART_STATUS, 32'h0000_0002);
    rd_chk("post_rst_baud", UART_BAUD, 32'd868);
    rd_chk("post_rst_ctrl", UART_CTRL, 32'd0);

`ifdef UART_TX_IRQ_EN
    begin
      int k = 0;
      bus_wr(UART_BAUD, 4'b0011, 32'd1);
      bus_wr(UART_TXDATA, 4'b0001, 32'h3C);
      bus_wr(UART_CTRL, 4'b0001, 32'd3);
      while (irq_o !== 1'b1 && k < 100) begin
        @(negedge clk_sys);
        k++;
      end
      chk("irq_delay", k, 12);
      rd_chk("irq_ctrl", UART_CTRL, 32'd3);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
